// File: rtl/muldiv_exe_unit.sv
// Iterative RV32M multiply/divide unit for the EXE stage; raises stall_req while busy.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiplies.
`timescale 1ns/1ps
module muldiv_exe_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic [2:0]          f3_q, f3_d;
  logic [4:0]          rd_q, rd_d;
  logic [4:0]          rd_out_q, rd_out_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Operand decode: sign handling, magnitudes and divide special cases
  logic            is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs, special_res;
  logic            div_special, fast_mul;
  logic [XLEN-1:0] fast_mul_res;

  always_comb begin
    is_div      = funct3[2];
    a_signed    = is_div ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
    b_signed    = is_div ? ~funct3[0] : (funct3 == 3'b001);
    a_neg       = a_signed & rs1_data[XLEN-1];
    b_neg       = b_signed & rs2_data[XLEN-1];
    a_abs       = a_neg ? -rs1_data : rs1_data;
    b_abs       = b_neg ? -rs2_data : rs2_data;
    special_res = '0;
    div_special = 1'b0;
    if (is_div && rs2_data == '0) begin
      div_special = 1'b1;
      special_res = funct3[1] ? rs1_data : '1;
    end else if (is_div && !funct3[0] && rs1_data == MIN_NEG && rs2_data == '1) begin
      div_special = 1'b1;
      special_res = funct3[1] ? '0 : MIN_NEG;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic a_ext, b_ext;
  logic signed [2*XLEN-1:0] fast_prod;
  always_comb begin
    a_ext        = a_signed & rs1_data[XLEN-1];
    b_ext        = b_signed & rs2_data[XLEN-1];
    // 33x33 signed product, sign-extended to 64 bits so the low 64 bits are exact
    fast_prod    = $signed({{XLEN{a_ext}}, rs1_data}) * $signed({{XLEN{b_ext}}, rs2_data});
    fast_mul     = ~is_div;
    fast_mul_res = (funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`else
  assign fast_mul     = 1'b0;
  assign fast_mul_res = '0;
`endif

  // One radix-2 iteration for each kind of operation
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   diff;
  logic              ge;
  logic [XLEN:0]     add;
  logic [2*XLEN-1:0] step_next, prod;
  logic [XLEN-1:0]   q_val, r_val, final_res;

  always_comb begin
    rem_sh = acc_q[2*XLEN-1:XLEN-1];
    ge     = rem_sh >= {1'b0, b_q};
    diff   = rem_sh[XLEN-1:0] - b_q;
    add    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    if (f3_q[2])
      step_next = ge ? {diff, acc_q[XLEN-2:0], 1'b1} : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else
      step_next = {add, acc_q[XLEN-1:1]};
    prod  = neg_q ? -step_next : step_next;
    q_val = step_next[XLEN-1:0];
    r_val = step_next[2*XLEN-1:XLEN];
    if (f3_q[2])
      final_res = f3_q[1] ? (rneg_q ? -r_val : r_val) : (neg_q ? -q_val : q_val);
    else
      final_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    res_d     = res_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    rd_out_d  = rd_out_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    stall_req = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          f3_d   = funct3;
          rd_d   = rd_in;
          b_d    = b_abs;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          acc_d  = {{XLEN{1'b0}}, a_abs};
          if (fast_mul) begin
            res_d    = fast_mul_res;
            rd_out_d = rd_in;
            state_d  = DONE;
          end else if (div_special) begin
            res_d     = special_res;
            rd_out_d  = rd_in;
            state_d   = DONE;
            stall_req = 1'b1;
          end else begin
            cnt_d     = CNT_W'(XLEN - 1);
            state_d   = CALC;
            stall_req = 1'b1;
          end
        end
      end
      CALC: begin
        stall_req = 1'b1;
        acc_d     = step_next;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          res_d    = final_res;
          rd_out_d = rd_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A killed op must leave the visible result untouched
    if (flush) begin
      state_d   = IDLE;
      cnt_d     = '0;
      res_d     = res_q;
      rd_out_d  = rd_out_q;
      stall_req = 1'b0;
      done      = 1'b0;
    end
    if (rst) begin
      stall_req = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      res_q    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      res_q    <= res_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign result = res_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_exe_unit.sv
// Testbench for muldiv_exe_unit: directed and random ops against an arithmetic reference model.
`timescale 1ns/1ps
module tb_muldiv_exe_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        stall_req, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_exe_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in), .flush(flush),
    .stall_req(stall_req), .done(done), .result(result), .rd_out(rd_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RV32M semantics from plain integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] u, pp;
    int          ia, ib, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    u  = {32'b0, a} * {32'b0, b};
    ia = a;
    ib = b;
    case (f3)
      3'd0: return u[31:0];
      3'd1: begin p = sa * sb; pp = p; return pp[63:32]; end
      3'd2: begin p = sa * ub; pp = p; return pp[63:32]; end
      3'd3: return u[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = ia / ib; return r;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        r = ia % ib; return r;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input bit skip_wait);
    logic [31:0] exp;
    int          lat, exp_stall, k, stall_cnt;
    bit          got_done, special;
    exp       = ref_model(f3, a, b);
    special   = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    lat       = special ? 1 : 33;
    exp_stall = lat;
`ifdef MULDIV_FAST_MUL_EN
    if (!f3[2]) begin lat = 1; exp_stall = 0; end
`endif
    if (!skip_wait) @(negedge clk);
    start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b; rd_in = rd;
    #1;
    stall_cnt = int'(stall_req);
    k = 0;
    got_done = 1'b0;
    while (!got_done && k < 40) begin
      @(negedge clk);
      k++;
      if (done) begin
        got_done = 1'b1;
        check({tag, " stall_at_done"}, 32'(stall_req), 32'd0);
      end else if (stall_req) begin
        stall_cnt++;
      end
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(k), 32'(lat));
    check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
    check({tag, " result"}, result, exp);
    check({tag, " rd_out"}, 32'(rd_out), 32'(rd));
    $display("op %s f3=%0d a=%h b=%h -> result=%h rd_out=%0d latency=%0d", tag, f3, a, b, result, rd_out, k);
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " result_hold"}, result, exp);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0;
    rs1_data = '0; rs2_data = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    check("reset stall_req", 32'(stall_req), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", 32'(rd_out), 32'd0);
    rst = 1'b0;

    do_op("divu_100_7",  3'd5, 32'd100, 32'd7, 5'd5, 1'b0);
    do_op("remu_100_7",  3'd7, 32'd100, 32'd7, 5'd6, 1'b0);
    do_op("div_m7_2",    3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b0);
    do_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b0);
    do_op("div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b0);
    do_op("rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0);
    do_op("divu_by_0",   3'd5, 32'd1234, 32'd0, 5'd11, 1'b0);
    do_op("remu_by_0",   3'd7, 32'd1234, 32'd0, 5'd12, 1'b0);
    do_op("div_by_0",    3'd4, 32'hFFFF_FF00, 32'd0, 5'd13, 1'b0);
    do_op("rem_by_0",    3'd6, 32'hFFFF_FF00, 32'd0, 5'd14, 1'b0);
    do_op("mulh_m1",     3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 1'b0);
    do_op("mulhu_m1",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 1'b0);
    do_op("mulhsu_m1",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 1'b0);
    do_op("mul_m1",      3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 1'b0);

    // Flush an iterative divide at N+10, then start a new one at N+11
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'd17; rd_in = 5'd20;
    repeat (10) begin
      @(negedge clk);
      check("flush pre done", 32'(done), 32'd0);
    end
    flush = 1'b1;
    #1;
    check("flush stall_req", 32'(stall_req), 32'd0);
    check("flush done", 32'(done), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    do_op("divu_after_flush", 3'd5, 32'd9, 32'd3, 5'd3, 1'b1);

    // Reset in the middle of a signed divide, start held through release
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; rs1_data = 32'hFFFF_FF9C; rs2_data = 32'd7; rd_in = 5'd12;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst stall_req", 32'(stall_req), 32'd0);
    check("rst done", 32'(done), 32'd0);
    @(negedge clk);
    check("rst result", result, 32'd0);
    check("rst rd_out", 32'(rd_out), 32'd0);
    check("rst done_next", 32'(done), 32'd0);
    check("rst stall_next", 32'(stall_req), 32'd0);
    rst = 1'b0;
    do_op("div_after_rst", 3'd4, 32'hFFFF_FF9C, 32'd7, 5'd12, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      logic [4:0]  rd;
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      rd = 5'($urandom_range(0, 31));
      do_op($sformatf("rand%0d", i), f3, a, b, rd, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
